// File: rtl/grant_seq.sv
// grant_seq: turns an encoded request {e1,e0}/nr into a one-hot grant held
// until ack or a HOLD_MAX-cycle timeout, followed by a one-cycle cool-down.
// Optional feature macro: GRANT_CNT_EN adds per-channel saturating grant
// counters read through cnt_sel; without it cnt is tied to zero.
module grant_seq #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e0,
  input  logic       e1,
  input  logic       nr,
  input  logic       ack,
  input  logic [1:0] cnt_sel,
  output logic [3:0] g,
  output logic [1:0] idx,
  output logic       busy,
  output logic       tout,
  output logic [7:0] cnt
);

  localparam int unsigned N_CH   = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nx;
  logic [N_CH-1:0]   g_nx;
  logic [IDX_W-1:0]  idx_nx;
  logic              busy_nx;
  logic              tout_nx;
  logic              start;
  logic              expire;

  assign expire = (hold == HOLD_LIM);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; ack wins over a coincident timeout
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!nr) state_nx = GRANT;
      GRANT:   if (ack || expire) state_nx = COOL;
      COOL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and the hold counter
  always_comb begin
    g_nx    = g;
    idx_nx  = idx;
    hold_nx = hold;
    tout_nx = 1'b0;
    start   = 1'b0;
    busy_nx = (state_nx != IDLE);
    unique case (state)
      IDLE: begin
        g_nx    = '0;
        hold_nx = '0;
        if (!nr) begin
          start   = 1'b1;
          idx_nx  = {e1, e0};
          g_nx    = N_CH'(1) << {e1, e0};
          hold_nx = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (ack) begin
          g_nx    = '0;
          hold_nx = '0;
        end else if (expire) begin
          g_nx    = '0;
          hold_nx = '0;
          tout_nx = 1'b1;
        end else begin
          hold_nx = hold + HOLD_W'(1);
        end
      end
      COOL: begin
        g_nx    = '0;
        hold_nx = '0;
      end
      default: begin
        g_nx    = '0;
        hold_nx = '0;
      end
    endcase
  end

  // Output and hold-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      g    <= '0;
      idx  <= '0;
      busy <= 1'b0;
      tout <= 1'b0;
      hold <= '0;
    end else begin
      g    <= g_nx;
      idx  <= idx_nx;
      busy <= busy_nx;
      tout <= tout_nx;
      hold <= hold_nx;
    end
  end

`ifdef GRANT_CNT_EN
  logic [CNT_W-1:0] gcnt [N_CH];

  // Per-channel grant counters, bumped on each IDLE->GRANT and saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) gcnt[i] <= '0;
    end else if (start && (gcnt[idx_nx] != {CNT_W{1'b1}})) begin
      gcnt[idx_nx] <= gcnt[idx_nx] + CNT_W'(1);
    end
  end

  assign cnt = gcnt[cnt_sel];
`else
  logic unused_cnt_inputs;

  assign unused_cnt_inputs = ^{cnt_sel, start};
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_grant_seq.sv
// tb_grant_seq: directed scoreboard bench for grant_seq (HOLD_MAX = 15).
// Expected cnt values follow GRANT_CNT_EN when the bench is built with it.
module tb_grant_seq;

  logic       clk;
  logic       rst;
  logic       e0;
  logic       e1;
  logic       nr;
  logic       ack;
  logic [1:0] cnt_sel;
  logic [3:0] g;
  logic [1:0] idx;
  logic       busy;
  logic       tout;
  logic [7:0] cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] idx;
    logic       busy;
    logic       tout;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  grant_seq #(.HOLD_MAX(15)) dut (
    .clk(clk), .rst(rst), .e0(e0), .e1(e1), .nr(nr), .ack(ack),
    .cnt_sel(cnt_sel), .g(g), .idx(idx), .busy(busy), .tout(tout), .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter readout for n grants on the selected channel
  function automatic logic [7:0] ecnt(input int n);
`ifdef GRANT_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'(n) & 8'h00;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
      $error("%s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge,
  // then pop and compare once the edge has passed.
  task automatic cyc(input logic [1:0] ev, input logic nrv, input logic ackv,
                     input logic rstv, input logic [3:0] eg, input logic [1:0] ei,
                     input logic eb, input logic et, input logic [7:0] ec);
    exp_t x;
    {e1, e0} = ev;
    nr  = nrv;
    ack = ackv;
    rst = rstv;
    x.g = eg; x.idx = ei; x.busy = eb; x.tout = et; x.cnt = ec;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("g",    8'(g),    8'(x.g));
    chk("idx",  8'(idx),  8'(x.idx));
    chk("busy", 8'(busy), 8'(x.busy));
    chk("tout", 8'(tout), 8'(x.tout));
    chk("cnt",  cnt,      x.cnt);
  endtask

  initial begin
    {e1, e0} = 2'd0; nr = 1'b1; ack = 1'b0; rst = 1'b1; cnt_sel = 2'd3;

    // Reset for two cycles, then idle with no request
    cyc(2'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0);
    cyc(2'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0);
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, ecnt(0));

    // Channel 2 granted for two cycles, acked, one COOL cycle
    cyc(2'd2, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, ecnt(0));
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, ecnt(0));
    cyc(2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, ecnt(0));
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, ecnt(0));
    // ack in IDLE has no effect
    cyc(2'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, ecnt(0));

    // Channel 1 with no ack: 15 grant cycles, encoder changes ignored, timeout
    cyc(2'd1, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, ecnt(0));
    for (int i = 0; i < 14; i++)
      cyc(2'(i), 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, ecnt(0));
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, ecnt(0));
    // nr=0 during COOL is not sampled
    cyc(2'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, ecnt(0));
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, ecnt(0));

    // Channel 0 acked exactly on the timeout edge: no tout
    cyc(2'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, ecnt(0));
    for (int i = 0; i < 14; i++)
      cyc(2'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, ecnt(0));
    cyc(2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, ecnt(0));
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, ecnt(0));

    // Back-to-back grants on channel 3 every 3 cycles; counter saturates
    for (int k = 1; k <= 300; k++) begin
      cyc(2'd3, 1'b0, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, ecnt(k));
      cyc(2'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b0, ecnt(k));
      cyc(2'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, ecnt(k));
    end

    // Readout of another channel
    cnt_sel = 2'd2;
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, ecnt(1));
    cnt_sel = 2'd3;

    // Grant channel 0, encoder moves to 1, then reset mid-GRANT
    cyc(2'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, ecnt(300));
    for (int i = 0; i < 3; i++)
      cyc(2'd1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, ecnt(300));
    cyc(2'd1, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0);

    // First edge after reset samples the request; counters were cleared
    cyc(2'd2, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 8'd0);
    cyc(2'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 8'd0);
    cyc(2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 8'd0);
    cnt_sel = 2'd2;
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, ecnt(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grant_seq.md
GRANT_SEQ -- requirements
Module: grant_seq

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum cycles a grant is held waiting for ack; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 e0  input  1  encoded index bit 0 from the upstream priority encoder.
REQ-005 e1  input  1  encoded index bit 1 from the upstream priority encoder.
REQ-006 nr  input  1  no-request flag from encoder; 1 = no request pending, 0 = {e1,e0} valid.
REQ-007 ack  input  1  consumer done with current grant.
REQ-008 cnt_sel  input  2  channel select for grant counter readout.
REQ-009 g  output  4  one-hot grant, g[i] = channel i granted.
REQ-010 idx  output  2  latched index of current or last grant.
REQ-011 busy  output  1  1 when FSM not in IDLE.
REQ-012 tout  output  1  one-cycle pulse on grant timeout.
REQ-013 cnt  output  8  grant count of channel cnt_sel.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, COOL; all outputs except cnt SHALL be registered.
REQ-015 IDLE: nr=0 sampled at edge k -> idx<={e1,e0}, state<=GRANT, g[idx]=1 from cycle k+1 (1-cycle latency); nr=1 -> stay IDLE, g=0.
REQ-016 GRANT: g SHALL hold the one-hot of latched idx; e0, e1, nr SHALL be ignored.
REQ-017 GRANT: ack=1 sampled -> g<=0, state<=COOL.
REQ-018 GRANT: hold counter starts at 1 on the grant cycle and increments each cycle; ack=0 when counter = HOLD_MAX -> g<=0, tout<=1 for exactly one cycle, state<=COOL.
REQ-019 ack=1 coincident with the timeout edge SHALL count as ack; tout stays 0.
REQ-020 COOL SHALL last exactly one cycle with g=0, then IDLE; nr=0 during COOL SHALL NOT be sampled.
REQ-021 ack outside GRANT SHALL be ignored.
REQ-022 Back-to-back: with nr held 0 and ack in the first grant cycle, grants SHALL recur every 3 cycles.
REQ-023 busy SHALL be 1 in GRANT and COOL, 0 in IDLE.
REQ-024 g SHALL never have more than one bit set.
REQ-025 idx SHALL retain the last granted index in IDLE and COOL.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, g=0, idx=0, busy=0, tout=0, hold counter=0, all grant counters=0.
REQ-027 Reset asserted mid-GRANT SHALL drop g at that edge without tout.
REQ-028 First request SHALL be sampled on the first edge with rst=0.

Configuration
REQ-029 Macro GRANT_CNT_EN SHALL gate per-channel grant counters.
REQ-030 GRANT_CNT_EN defined: four 8-bit counters, counter[idx] +1 on each IDLE->GRANT transition, saturating at 255; cnt = counter[cnt_sel] combinationally.
REQ-031 GRANT_CNT_EN undefined: no counter registers; cnt constant 0; ports unchanged; all other behaviour identical.

Verification
REQ-032 rst=1 2 cycles, nr=1 -> g=0, idx=0, busy=0, tout=0, cnt=0.
REQ-033 {e1,e0}=2'b10, nr=0 one cycle, ack=1 two cycles later -> g=4'b0100 for 2 cycles, idx=2, then 1 COOL cycle, busy=0 next.
REQ-034 {e1,e0}=2'b01, nr=0, ack never, HOLD_MAX=15 -> g=4'b0010 for 15 cycles, tout=1 for 1 cycle, IDLE after COOL.
REQ-035 nr=0 held, {e1,e0}=3, ack=1 always -> g=4'b1000 in 1 of every 3 cycles; with GRANT_CNT_EN, cnt_sel=3 reads 10 after 10 grants, 255 after 300.
REQ-036 Change {e1,e0} 0->1 during GRANT idx 0, then rst=1 mid-GRANT -> g stays 4'b0001 until reset edge, then g=0, tout=0.
REQ-037 ack=1 on the exact timeout cycle -> tout=0, normal COOL.
